// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the multi-port register file with scoreboard.
// Provides default geometry, the hardwired-zero register index and an
// address helper used by both the write path and every read port.
package regfile_mp_sb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;

    // Register 0 always reads as zero and can never be written or marked busy.
    localparam int REG_ZERO = 0;

    // True when addr names a real, writable register: non-zero and below NUM_REGS.
    function automatic logic addr_in_range(input int addr, input int num_regs);
        return (addr != REG_ZERO) && (addr < num_regs);
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between decode/writeback and the register file.
// master: drives write port, read requests and scoreboard set; samples read results.
// slave:  the register file side (rd, rd_busy, any_busy are its outputs).
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);
    logic                       regwrite;
    logic [ADDR_W-1:0]          wa;
    logic [DATA_W-1:0]          wd;
    logic [NUM_RD-1:0]          ren;
    logic [NUM_RD*ADDR_W-1:0]   ra;
    logic [NUM_RD*DATA_W-1:0]   rd;
    logic [NUM_RD-1:0]          rd_busy;
    logic                       sb_set;
    logic [ADDR_W-1:0]          sb_addr;
    logic                       any_busy;

    modport master (
        output regwrite, wa, wd, ren, ra, sb_set, sb_addr,
        input  rd, rd_busy, any_busy
    );

    modport slave (
        input  regwrite, wa, wd, ren, ra, sb_set, sb_addr,
        output rd, rd_busy, any_busy
    );
endinterface

// File: rtl/regfile_mp_sb_read_port.sv
// One read port: zero/range check, optional same-cycle write bypass, output registers.
// Latency 1 clk from ra to rd/rd_busy.
// No backpressure; ren=0 holds rd and rd_busy at their previous values.
// Ports: clk, reset (async, active-high); ren/ra request; regwrite/wa/wd snooped for bypass;
//        stored/busy_in are the array contents at ra; rd/rd_busy registered results.
module regfile_mp_sb_read_port
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int BYPASS   = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              ren,
    input  logic [ADDR_W-1:0] ra,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] stored,
    input  logic              busy_in,
    output logic [DATA_W-1:0] rd,
    output logic              rd_busy
);

    logic              ra_ok;
    logic              bypass_hit;
    logic [DATA_W-1:0] rd_next;

    assign ra_ok = addr_in_range(int'(ra), NUM_REGS);

    // ra_ok also guarantees wa is a real register when the addresses match,
    // so a write to r0 or out of range can never leak through the bypass.
    assign bypass_hit = (BYPASS != 0) && regwrite && (wa == ra) && ra_ok;

    always_comb begin
        rd_next = '0;
        if (ra_ok) begin
            rd_next = bypass_hit ? wd : stored;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd      <= '0;
            rd_busy <= 1'b0;
        end else if (ren) begin
            rd      <= rd_next;
            rd_busy <= ra_ok && busy_in;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass and per-register busy scoreboard.
// Latency: write visible to a plain read 1 clk later (same cycle with BYPASS=1); reads 1 clk.
// No backpressure; all requests accepted every cycle, ren=0 holds a port's outputs.
// Ports: clk, reset (async, active-high); bus (slave) carries the write port
//        (regwrite/wa/wd), read ports (ren/ra -> rd/rd_busy) and scoreboard (sb_set/sb_addr, any_busy).
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int BYPASS   = 1
)(
    input  logic           clk,
    input  logic           reset,
    regfile_mp_sb_if.slave bus
);

    generate
        if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
            $error("regfile_mp_sb: NUM_RD must be in 1..4");
        end
        if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr_w
            $error("regfile_mp_sb: ADDR_W too narrow for NUM_REGS");
        end
    endgenerate

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                any_busy_q;
    logic                wr_ok;
    logic                set_ok;

    logic [DATA_W-1:0]   rd_arr      [NUM_RD];
    logic                rd_busy_arr [NUM_RD];

    assign wr_ok  = bus.regwrite && addr_in_range(int'(bus.wa), NUM_REGS);
    assign set_ok = bus.sb_set   && addr_in_range(int'(bus.sb_addr), NUM_REGS);

    // Writeback clears, load issue sets; set is applied last so it wins a same-cycle collision.
    always_comb begin
        busy_next    = busy_q;
        busy_next[0] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_ok && (bus.wa == ADDR_W'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (set_ok && (bus.sb_addr == ADDR_W'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[bus.wa] <= bus.wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_next;
            any_busy_q <= |busy_next;
        end
    end

    assign bus.any_busy = any_busy_q;

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] ra_p;
            logic [ADDR_W-1:0] ra_idx;

            assign ra_p = bus.ra[p*ADDR_W +: ADDR_W];
            // Clamp so the array is never indexed past its end; the port zeroes
            // out-of-range results anyway.
            assign ra_idx = (int'(ra_p) < NUM_REGS) ? ra_p : '0;

            regfile_mp_sb_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .NUM_REGS (NUM_REGS),
                .BYPASS   (BYPASS)
            ) u_read_port (
                .clk      (clk),
                .reset    (reset),
                .ren      (bus.ren[p]),
                .ra       (ra_p),
                .regwrite (bus.regwrite),
                .wa       (bus.wa),
                .wd       (bus.wd),
                .stored   (regs_q[ra_idx]),
                .busy_in  (busy_next[ra_idx]),
                .rd       (rd_arr[p]),
                .rd_busy  (rd_busy_arr[p])
            );
        end
    endgenerate

    always_comb begin
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd[p*DATA_W +: DATA_W] = rd_arr[p];
            bus.rd_busy[p]             = rd_busy_arr[p];
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: three instances share one stimulus stream --
// the default file (BYPASS=1, 32 regs), a BYPASS=0 file and a 24-register file.
// Expected values are hand-computed per step.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        regwrite = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [1:0]  ren = '0;
    logic [4:0]  ra0 = '0;
    logic [4:0]  ra1 = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b_main ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b_nb   ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b_r24  ();

    assign b_main.regwrite = regwrite; assign b_nb.regwrite = regwrite; assign b_r24.regwrite = regwrite;
    assign b_main.wa       = wa;       assign b_nb.wa       = wa;       assign b_r24.wa       = wa;
    assign b_main.wd       = wd;       assign b_nb.wd       = wd;       assign b_r24.wd       = wd;
    assign b_main.ren      = ren;      assign b_nb.ren      = ren;      assign b_r24.ren      = ren;
    assign b_main.ra       = {ra1, ra0};
    assign b_nb.ra         = {ra1, ra0};
    assign b_r24.ra        = {ra1, ra0};
    assign b_main.sb_set   = sb_set;   assign b_nb.sb_set   = sb_set;   assign b_r24.sb_set   = sb_set;
    assign b_main.sb_addr  = sb_addr;  assign b_nb.sb_addr  = sb_addr;  assign b_r24.sb_addr  = sb_addr;

    regfile_mp_sb #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1))
        u_dut (.clk(clk), .reset(reset), .bus(b_main));
    regfile_mp_sb #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0))
        u_nb  (.clk(clk), .reset(reset), .bus(b_nb));
    regfile_mp_sb #(.DATA_W(32), .NUM_REGS(24), .ADDR_W(5), .NUM_RD(2), .BYPASS(1))
        u_r24 (.clk(clk), .reset(reset), .bus(b_r24));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwrite = 1'b0;
        sb_set   = 1'b0;
        ren      = 2'b00;
    endtask

    initial begin
        // Reset state while reset is held across an edge.
        tick();
        check("rst_rd", b_main.rd[31:0], 32'h0);
        check("rst_busy", 32'(b_main.rd_busy), 32'h0);
        check("rst_any", 32'(b_main.any_busy), 32'h0);
        reset = 1'b0;

        // 1. Every register reads zero on both ports after reset.
        for (int a = 0; a < 32; a++) begin
            ren = 2'b11; ra0 = 5'(a); ra1 = 5'(31 - a);
            tick();
            check("t1_rd0", b_main.rd[31:0], 32'h0);
            check("t1_rd1", b_main.rd[63:32], 32'h0);
            check("t1_busy", 32'(b_main.rd_busy), 32'h0);
            check("t1_any", 32'(b_main.any_busy), 32'h0);
        end
        idle();

        // 2. Write r5, read it back; r0 ignores writes even under bypass.
        regwrite = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        regwrite = 1'b0; ren = 2'b01; ra0 = 5'd5;
        tick();
        check("t2_r5", b_main.rd[31:0], 32'hDEADBEEF);
        check("t2_r5_nb", b_nb.rd[31:0], 32'hDEADBEEF);
        check("t2_r5_r24", b_r24.rd[31:0], 32'hDEADBEEF);
        regwrite = 1'b1; wa = 5'd0; wd = 32'h00001234; ra0 = 5'd0;
        tick();
        check("t2_r0_byp", b_main.rd[31:0], 32'h0);
        regwrite = 1'b0;
        tick();
        check("t2_r0", b_main.rd[31:0], 32'h0);

        // 3. Same-cycle write/read of r7: bypass vs old value.
        regwrite = 1'b1; wa = 5'd7; wd = 32'h11112222; ren = 2'b00;
        tick();
        wd = 32'hA5A5A5A5; ren = 2'b10; ra1 = 5'd7;
        tick();
        check("t3_byp", b_main.rd[63:32], 32'hA5A5A5A5);
        check("t3_nobyp", b_nb.rd[63:32], 32'h11112222);
        regwrite = 1'b0;
        tick();
        check("t3_after_nb", b_nb.rd[63:32], 32'hA5A5A5A5);

        // 4. Scoreboard set / clear / set-wins on r3.
        ren = 2'b01; ra0 = 5'd3; sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        check("t4_set_busy", 32'(b_main.rd_busy[0]), 32'h1);
        check("t4_set_any", 32'(b_main.any_busy), 32'h1);
        sb_set = 1'b0;
        tick();
        check("t4_hold_busy", 32'(b_main.rd_busy[0]), 32'h1);
        regwrite = 1'b1; wa = 5'd3; wd = 32'h00000033;
        tick();
        check("t4_clr_busy", 32'(b_main.rd_busy[0]), 32'h0);
        check("t4_clr_any", 32'(b_main.any_busy), 32'h0);
        check("t4_clr_data", b_main.rd[31:0], 32'h00000033);
        wd = 32'h00000044; sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        check("t4_setwin_busy", 32'(b_main.rd_busy[0]), 32'h1);
        check("t4_setwin_any", 32'(b_main.any_busy), 32'h1);
        regwrite = 1'b0; sb_set = 1'b0; ren = 2'b11; ra1 = 5'd3;
        tick();
        check("t4_same_rd", b_main.rd[63:32], 32'h00000044);
        check("t4_same_rd0", b_main.rd[31:0], 32'h00000044);
        check("t4_same_busy", 32'(b_main.rd_busy), 32'h3);

        // 5. Port 1 disabled: outputs hold while its address and r3 change.
        ren = 2'b01; ra0 = 5'd7;
        for (int c = 0; c < 3; c++) begin
            ra1 = (c == 0) ? 5'd5 : (c == 1) ? 5'd7 : 5'd2;
            regwrite = (c == 0); wa = 5'd3; wd = 32'h00000099;
            tick();
            check("t5_hold_rd1", b_main.rd[63:32], 32'h00000044);
            check("t5_hold_busy1", 32'(b_main.rd_busy[1]), 32'h1);
            check("t5_rd0", b_main.rd[31:0], 32'hA5A5A5A5);
        end
        check("t5_any", 32'(b_main.any_busy), 32'h0);

        // 6. Out-of-range address 30 on the 24-register file; in-range on the 32.
        regwrite = 1'b1; wa = 5'd30; wd = 32'h0000CAFE;
        sb_set = 1'b1; sb_addr = 5'd30; ren = 2'b11; ra0 = 5'd30; ra1 = 5'd30;
        tick();
        check("t6_r24_rd", b_r24.rd[31:0], 32'h0);
        check("t6_r24_busy", 32'(b_r24.rd_busy), 32'h0);
        check("t6_r24_any", 32'(b_r24.any_busy), 32'h0);
        check("t6_main_rd", b_main.rd[31:0], 32'h0000CAFE);
        check("t6_main_busy", 32'(b_main.rd_busy), 32'h3);
        regwrite = 1'b0; sb_set = 1'b0;
        tick();
        check("t6_r24_rd_after", b_r24.rd[63:32], 32'h0);
        check("t6_main_rd_after", b_main.rd[63:32], 32'h0000CAFE);
        regwrite = 1'b1; wa = 5'd23; wd = 32'h00002323; ren = 2'b10; ra1 = 5'd23;
        tick();
        check("t6_r24_r23", b_r24.rd[63:32], 32'h00002323);

        // Reset during pending busy clears outputs immediately.
        regwrite = 1'b0; sb_set = 1'b1; sb_addr = 5'd9; ren = 2'b00;
        tick();
        check("t6_pre_rst_any", 32'(b_main.any_busy), 32'h1);
        sb_set = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_rst_any", 32'(b_main.any_busy), 32'h0);
        check("t6_rst_rd", b_main.rd[63:32], 32'h0);
        check("t6_rst_busy", 32'(b_main.rd_busy), 32'h0);
        tick();
        reset = 1'b0;
        ren = 2'b11; ra0 = 5'd5; ra1 = 5'd9;
        tick();
        check("t6_post_r5", b_main.rd[31:0], 32'h0);
        check("t6_post_busy", 32'(b_main.rd_busy), 32'h0);
        check("t6_post_any", 32'(b_main.any_busy), 32'h0);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
